// File: rtl/axi_wr_arb_pkg.sv
// Shared types and constants for the AXI write-channel arbiter.
package axi_wr_arb_pkg;

    // Transaction phases: arbitrate, address, data burst, write response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // The beat counter is loaded with awlen and counts down; zero marks the last beat
    function automatic logic is_last_beat(input logic [7:0] cnt);
        return (cnt == 8'd0);
    endfunction

endpackage

// File: rtl/axi_wr_arb_pick.sv
// Combinational request-to-grant picker: the first asserted request found
// when scanning upward from ptr (wrapping at NUM_REQ) wins.
// With ptr tied to zero this is plain fixed priority, lowest index first.
module axi_wr_arb_pick #(
    parameter int NUM_REQ = 4,
    parameter int GW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      ptr,
    output logic               valid,
    output logic [GW-1:0]      idx
);

    localparam int unsigned N = NUM_REQ;

    // Rotating scan from ptr; the first hit is kept
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            int unsigned j;
            logic [GW-1:0] jg;
            j = 32'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            jg = GW'(j);
            if (!valid && req[jg]) begin
                valid = 1'b1;
                idx   = jg;
            end
        end
    end

endmodule

// File: rtl/axi_write_arbiter.sv
// Shares one AXI write channel (AW/W/B) between NUM_REQ requesters, one
// whole transaction per grant. m_wlast is generated from awlen; requester
// wlast is only checked and reported on len_err.
// Build option: define AXI_WR_ARB_RR_EN for round-robin arbitration,
// otherwise fixed priority (lowest index wins).
module axi_write_arbiter
    import axi_wr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int GW      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      s_awvalid,
    output logic [NUM_REQ-1:0]      s_awready,
    input  logic [NUM_REQ*AW-1:0]   s_awaddr,
    input  logic [NUM_REQ*8-1:0]    s_awlen,
    input  logic [NUM_REQ*3-1:0]    s_awsize,
    input  logic [NUM_REQ*2-1:0]    s_awburst,
    input  logic [NUM_REQ-1:0]      s_wvalid,
    output logic [NUM_REQ-1:0]      s_wready,
    input  logic [NUM_REQ*DW-1:0]   s_wdata,
    input  logic [NUM_REQ*DW/8-1:0] s_wstrb,
    input  logic [NUM_REQ-1:0]      s_wlast,
    output logic [NUM_REQ-1:0]      s_bvalid,
    input  logic [NUM_REQ-1:0]      s_bready,
    output logic [1:0]              s_bresp,
    output logic [AW-1:0]           m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DW-1:0]           m_wdata,
    output logic [DW/8-1:0]         m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [GW-1:0]           grant_id,
    output logic                    busy,
    output logic                    len_err
);

    localparam int SW = DW / 8;

    arb_state_t    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [7:0]    beat_cnt_q, beat_cnt_d;
    logic          busy_q, busy_d;
    logic          len_err_q, len_err_d;
    logic          pick_valid;
    logic [GW-1:0] pick_idx;
    logic [GW-1:0] pick_ptr;
    logic          aw_hs, w_hs, b_hs;

`ifdef AXI_WR_ARB_RR_EN
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    assign pick_ptr = rr_ptr_q;
`else
    assign pick_ptr = '0;
`endif

    axi_wr_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_pick (
        .req   (s_awvalid),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Owner's payload is always muxed through; only valid/ready are gated by phase
    assign m_awaddr  = s_awaddr [grant_q*AW +: AW];
    assign m_awlen   = s_awlen  [grant_q*8  +: 8];
    assign m_awsize  = s_awsize [grant_q*3  +: 3];
    assign m_awburst = s_awburst[grant_q*2  +: 2];
    assign m_wdata   = s_wdata  [grant_q*DW +: DW];
    assign m_wstrb   = s_wstrb  [grant_q*SW +: SW];
    assign s_bresp   = m_bresp;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign len_err   = len_err_q;

    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid  & m_wready;
    assign b_hs  = m_bvalid  & m_bready;

    // Handshake routing: only the owner's channel in the active phase is connected
    always_comb begin
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_wlast   = 1'b0;
        m_bready  = 1'b0;
        unique case (state_q)
            ADDR: begin
                m_awvalid          = s_awvalid[grant_q];
                s_awready[grant_q] = m_awready;
            end
            DATA: begin
                m_wvalid          = s_wvalid[grant_q];
                m_wlast           = is_last_beat(beat_cnt_q);
                s_wready[grant_q] = m_wready;
            end
            RESP: begin
                s_bvalid[grant_q] = m_bvalid;
                m_bready          = s_bready[grant_q];
            end
            default: ;
        endcase
    end

    // Next-state logic: arbitration, burst counting and wlast checking
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        len_err_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (aw_hs) begin
                    beat_cnt_d = m_awlen;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    len_err_d = (s_wlast[grant_q] != m_wlast);
                    if (is_last_beat(beat_cnt_q)) begin
                        state_d = RESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 8'd1;
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

`ifdef AXI_WR_ARB_RR_EN
    // Round-robin pointer moves past the owner once its response completes
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == RESP && b_hs) begin
            rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
    end
`endif

    // State and registered outputs; reset abandons any in-flight burst
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
            len_err_q  <= 1'b0;
`ifdef AXI_WR_ARB_RR_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            busy_q     <= busy_d;
            len_err_q  <= len_err_d;
`ifdef AXI_WR_ARB_RR_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Self-checking bench for axi_write_arbiter: randomized requesters and slave
// handshakes, compared against a transaction-level reference model.
module tb_axi_write_arbiter;
    import axi_wr_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int GW = 2;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic [N*AW-1:0] s_awaddr;
    logic [N*8-1:0]  s_awlen;
    logic [N*3-1:0]  s_awsize;
    logic [N*2-1:0]  s_awburst;
    logic [N*DW-1:0] s_wdata;
    logic [N*SW-1:0] s_wstrb;
    logic [1:0]      s_bresp, m_bresp, m_awburst;
    logic [AW-1:0]   m_awaddr;
    logic [7:0]      m_awlen;
    logic [2:0]      m_awsize;
    logic            m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [DW-1:0]   m_wdata;
    logic [SW-1:0]   m_wstrb;
    logic [GW-1:0]   grant_id;
    logic            busy, len_err;

    // Per-requester stimulus, packed onto the flat DUT ports
    logic [AW-1:0] r_addr [N];
    logic [7:0]    r_len  [N];
    logic [DW-1:0] r_wdata[N];
    logic [SW-1:0] r_wstrb[N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign s_awaddr [g*AW +: AW] = r_addr[g];
        assign s_awlen  [g*8  +: 8]  = r_len[g];
        assign s_awsize [g*3  +: 3]  = 3'd3;
        assign s_awburst[g*2  +: 2]  = BURST_INCR;
        assign s_wdata  [g*DW +: DW] = r_wdata[g];
        assign s_wstrb  [g*SW +: SW] = r_wstrb[g];
    end

    axi_write_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .GW(GW)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .grant_id(grant_id), .busy(busy), .len_err(len_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Monotonic event counters sampled at negedge; tests diff snapshots
    int   lerr_total = 0;
    int   lerr_pairs = 0;
    int   iso_bad    = 0;
    logic prev_lerr  = 1'b0;
    bit   iso_en     = 1'b0;
    always @(negedge clk) begin
        if (len_err === 1'b1) begin
            lerr_total++;
            if (prev_lerr) lerr_pairs++;
        end
        prev_lerr = (len_err === 1'b1);
        if (iso_en && (s_wready[1] !== 1'b0 || s_bvalid[1] !== 1'b0 || s_awready[1] !== 1'b0))
            iso_bad++;
    end

    // Reference model: next search start; stays 0 under fixed priority
    int model_ptr = 0;

    function automatic int model_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (((req >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    task automatic model_done(input int winner);
`ifdef AXI_WR_ARB_RR_EN
        model_ptr = (winner + 1) % N;
`else
        model_ptr = 0;
        if (winner < 0) model_ptr = 0;
`endif
    endtask

    typedef struct {
        int gid, gwait, cycles, hs, wlast_bad, data_bad;
        bit aw_ok, b_ok, overrun, idle_ok, timeout;
    } txn_res_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stim();
        s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = RESP_OKAY;
        for (int i = 0; i < N; i++) begin
            r_addr[i] = '0; r_len[i] = '0; r_wdata[i] = '0; r_wstrb[i] = '0;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_ptr = 0;
    endtask

    // Drives one transaction starting from IDLE with requests already raised;
    // the owner is whichever requester the DUT grants, reported in gid.
    task automatic do_txn(input bit keep_req, input bit rnd, input int bad_beat,
                          input bit delay_b, output txn_res_t r);
        int len, beat;
        logic [GW-1:0] gi;
        logic [N-1:0]  oh;
        logic [1:0]    bresp;
        r = '{gid: -1, gwait: 0, cycles: 0, hs: 0, wlast_bad: 0, data_bad: 0,
              aw_ok: 1'b0, b_ok: 1'b1, overrun: 1'b0, idle_ok: 1'b0, timeout: 1'b0};
        m_awready = 1'b1;
        do begin
            tick();
            r.cycles++;
        end while (busy !== 1'b1 && r.cycles < 50);
        r.gwait = r.cycles;
        if (busy !== 1'b1) begin
            r.timeout = 1'b1;
            return;
        end
        gi    = grant_id;
        r.gid = int'(gi);
        len   = int'(r_len[gi]);
        oh    = N'(1 << r.gid);
        r.aw_ok = (m_awvalid === 1'b1) && (s_awready === oh) && (m_awaddr === r_addr[gi]) &&
                  (m_awlen === r_len[gi]) && (m_awsize === 3'd3) && (m_awburst === BURST_INCR) &&
                  (s_wready === '0) && (m_wvalid === 1'b0);
        tick();
        r.cycles++;
        if (!keep_req) s_awvalid[gi] = 1'b0;
        beat = 0;
        while (beat <= len) begin
            if (r.cycles > 4000) begin
                r.timeout = 1'b1;
                s_wvalid[gi] = 1'b0;
                return;
            end
            m_wready     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_wvalid[gi] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            r_wdata[gi]  = {$urandom, $urandom};
            r_wstrb[gi]  = SW'($urandom);
            s_wlast[gi]  = (beat == len) || (bad_beat >= 0 && beat >= bad_beat);
            #1;
            if (m_wvalid !== s_wvalid[gi] || m_wdata !== r_wdata[gi] || m_wstrb !== r_wstrb[gi] ||
                s_wready !== (m_wready ? oh : '0))
                r.data_bad++;
            if (m_wvalid === 1'b1 && m_wready === 1'b1) begin
                r.hs++;
                if (m_wlast !== (beat == len)) r.wlast_bad++;
            end
            if (s_wvalid[gi] && m_wready) beat++;
            tick();
            r.cycles++;
        end
        // Burst complete: the owner keeps offering data, nothing more may pass
        s_wvalid[gi] = 1'b1;
        m_wready     = 1'b1;
        #1;
        r.overrun = (m_wvalid !== 1'b0) || (s_wready !== '0);
        s_wvalid[gi] = 1'b0;
        s_wlast[gi]  = 1'b0;
        s_bready[gi] = 1'b1;
        if (delay_b) begin
            m_bvalid = 1'b0;
            #1;
            if (s_bvalid !== '0 || m_bready !== 1'b1) r.b_ok = 1'b0;
            tick();
            r.cycles++;
        end
        bresp    = 2'($urandom);
        m_bvalid = 1'b1;
        m_bresp  = bresp;
        #1;
        if (s_bvalid !== oh || s_bresp !== bresp || m_bready !== 1'b1) r.b_ok = 1'b0;
        tick();
        r.cycles++;
        m_bvalid     = 1'b0;
        s_bready[gi] = 1'b0;
        #1;
        r.idle_ok = (busy === 1'b0) && (s_bvalid === '0) && (m_bready === 1'b0);
    endtask

    task automatic test_reset();
        clear_stim();
        s_awvalid = '1;
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (grant_id !== '0) begin n_bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        n_cmp++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b000) begin n_bad++;
            $display("FAIL reset_m_ctl: got %b want 000", {m_awvalid, m_wvalid, m_bready}); end
        n_cmp++; if ({s_awready, s_wready, s_bvalid} !== '0) begin n_bad++;
            $display("FAIL reset_s_ctl: got %b want 0", {s_awready, s_wready, s_bvalid}); end
        n_cmp++; if (len_err !== 1'b0) begin n_bad++; $display("FAIL reset_len_err: got %b want 0", len_err); end
        rst = 1'b0;
        s_awvalid = '0;
        model_ptr = 0;
        tick();
    endtask

    task automatic test_single();
        txn_res_t res;
        int l0, exp;
        r_addr[0] = $urandom;
        r_len[0]  = 8'd3;
        s_awvalid = 4'b0001;
        exp = model_pick(s_awvalid, model_ptr);
        l0 = lerr_total;
        do_txn(1'b0, 1'b0, -1, 1'b1, res);
        model_done(exp);
        n_cmp++; if (res.gid !== exp || res.gwait !== 1) begin n_bad++;
            $display("FAIL single_grant: got id=%0d wait=%0d want id=%0d wait=1", res.gid, res.gwait, exp); end
        n_cmp++; if (!res.aw_ok) begin n_bad++; $display("FAIL single_aw: got aw_ok=0 want 1"); end
        n_cmp++; if (res.hs !== 4 || res.wlast_bad !== 0 || res.data_bad !== 0 || res.overrun) begin n_bad++;
            $display("FAIL single_wbeats: got hs=%0d wlast_bad=%0d data_bad=%0d overrun=%0b want 4/0/0/0",
                     res.hs, res.wlast_bad, res.data_bad, res.overrun); end
        n_cmp++; if (!res.b_ok || !res.idle_ok || res.timeout) begin n_bad++;
            $display("FAIL single_resp: got b_ok=%0b idle_ok=%0b timeout=%0b want 1/1/0", res.b_ok, res.idle_ok, res.timeout); end
        n_cmp++; if (lerr_total - l0 !== 0) begin n_bad++; $display("FAIL single_len_err: got %0d pulses want 0", lerr_total - l0); end
    endtask

    task automatic test_contention();
        txn_res_t res;
        int exp;
        pulse_reset();
        for (int i = 0; i < N; i++) begin
            r_addr[i] = $urandom;
            r_len[i]  = 8'd0;
        end
        s_awvalid = '1;
        for (int t = 0; t < N; t++) begin
            exp = model_pick(s_awvalid, model_ptr);
            do_txn(1'b1, 1'b0, -1, 1'b0, res);
            model_done(exp);
            n_cmp++; if (res.gid !== exp || res.cycles !== 4) begin n_bad++;
                $display("FAIL contention_order[%0d]: got id=%0d cycles=%0d want id=%0d cycles=4", t, res.gid, res.cycles, exp); end
        end
        s_awvalid = '0;
    endtask

    task automatic test_max_burst();
        txn_res_t res;
        int r, l0;
        r = $urandom_range(0, N - 1);
        r_addr[r] = $urandom;
        r_len[r]  = 8'd255;
        s_awvalid = N'(1 << r);
        l0 = lerr_total;
        do_txn(1'b0, 1'b1, -1, 1'b0, res);
        model_done(r);
        n_cmp++; if (res.gid !== r) begin n_bad++; $display("FAIL maxburst_grant: got %0d want %0d", res.gid, r); end
        n_cmp++; if (res.hs !== 256 || res.overrun || res.timeout) begin n_bad++;
            $display("FAIL maxburst_beats: got hs=%0d overrun=%0b timeout=%0b want 256/0/0", res.hs, res.overrun, res.timeout); end
        n_cmp++; if (res.wlast_bad !== 0 || res.data_bad !== 0) begin n_bad++;
            $display("FAIL maxburst_wlast: got wlast_bad=%0d data_bad=%0d want 0/0", res.wlast_bad, res.data_bad); end
        n_cmp++; if (lerr_total - l0 !== 0) begin n_bad++; $display("FAIL maxburst_len_err: got %0d want 0", lerr_total - l0); end
    endtask

    task automatic test_len_mismatch();
        txn_res_t res;
        int l0, p0;
        r_addr[1] = $urandom;
        r_len[1]  = 8'd1;
        s_awvalid = 4'b0010;
        l0 = lerr_total;
        p0 = lerr_pairs;
        do_txn(1'b0, 1'b0, 0, 1'b0, res);
        tick();
        model_done(1);
        n_cmp++; if (lerr_total - l0 !== 1 || lerr_pairs - p0 !== 0) begin n_bad++;
            $display("FAIL lenerr_pulse: got %0d cycles (%0d consecutive) want 1 (0)", lerr_total - l0, lerr_pairs - p0); end
        n_cmp++; if (res.hs !== 2 || res.wlast_bad !== 0 || res.overrun || res.data_bad !== 0) begin n_bad++;
            $display("FAIL lenerr_burst: got hs=%0d wlast_bad=%0d overrun=%0b want 2/0/0", res.hs, res.wlast_bad, res.overrun); end
    endtask

    task automatic test_reset_mid_data();
        txn_res_t res;
        r_addr[2] = $urandom;
        r_len[2]  = 8'd3;
        s_awvalid = 4'b0100;
        m_awready = 1'b1;
        tick();
        tick();
        s_awvalid[2] = 1'b0;
        s_wvalid[2]  = 1'b1;
        s_wlast[2]   = 1'b0;
        m_wready     = 1'b1;
        tick();
        tick();
        n_cmp++; if (busy !== 1'b1 || m_wvalid !== 1'b1) begin n_bad++;
            $display("FAIL midreset_pre: got busy=%b m_wvalid=%b want 1/1", busy, m_wvalid); end
        rst = 1'b1;
        tick();
        n_cmp++; if ({busy, m_wvalid, m_awvalid, m_bready} !== 4'b0000 || grant_id !== '0 || len_err !== 1'b0) begin n_bad++;
            $display("FAIL midreset_ctl: got busy=%b wv=%b awv=%b bready=%b gid=%0d lerr=%b want all 0",
                     busy, m_wvalid, m_awvalid, m_bready, grant_id, len_err); end
        n_cmp++; if ({s_awready, s_wready, s_bvalid} !== '0) begin n_bad++;
            $display("FAIL midreset_s_ctl: got %b want 0", {s_awready, s_wready, s_bvalid}); end
        rst = 1'b0;
        s_wvalid  = '0;
        model_ptr = 0;
        r_addr[3] = $urandom;
        r_len[3]  = 8'($urandom_range(0, 7));
        s_awvalid = 4'b1000;
        do_txn(1'b0, 1'b0, -1, 1'b0, res);
        model_done(3);
        n_cmp++; if (res.gid !== 3 || res.gwait !== 1 || res.hs !== int'(r_len[3]) + 1 || res.data_bad !== 0 || !res.b_ok) begin n_bad++;
            $display("FAIL midreset_after: got id=%0d wait=%0d hs=%0d data_bad=%0d b_ok=%0b want 3/1/%0d/0/1",
                     res.gid, res.gwait, res.hs, res.data_bad, res.b_ok, int'(r_len[3]) + 1); end
    endtask

    task automatic test_isolation();
        txn_res_t res;
        int i0;
        r_addr[2] = $urandom;
        r_len[2]  = 8'($urandom_range(0, 3));
        s_wvalid[1] = 1'b1;
        s_bready[1] = 1'b1;
        s_awvalid   = 4'b0100;
        i0 = iso_bad;
        iso_en = 1'b1;
        do_txn(1'b0, 1'b0, -1, 1'b1, res);
        iso_en = 1'b0;
        model_done(2);
        s_wvalid[1] = 1'b0;
        s_bready[1] = 1'b0;
        n_cmp++; if (res.gid !== 2 || !res.b_ok || res.data_bad !== 0) begin n_bad++;
            $display("FAIL isolation_owner: got id=%0d b_ok=%0b data_bad=%0d want 2/1/0", res.gid, res.b_ok, res.data_bad); end
        n_cmp++; if (iso_bad - i0 !== 0) begin n_bad++;
            $display("FAIL isolation_leak: got %0d cycles with req1 ready/bvalid want 0", iso_bad - i0); end
    endtask

    task automatic test_random();
        txn_res_t res;
        int exp;
        logic [N-1:0] mask;
        for (int t = 0; t < 12; t++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                r_addr[i] = $urandom;
                r_len[i]  = 8'($urandom_range(0, 7));
            end
            s_awvalid = mask;
            exp = model_pick(mask, model_ptr);
            do_txn(1'b1, 1'b1, -1, 1'($urandom_range(0, 1)), res);
            model_done(exp);
            n_cmp++; if (res.gid !== exp) begin n_bad++;
                $display("FAIL random_grant[%0d]: mask=%b got %0d want %0d", t, mask, res.gid, exp); end
            n_cmp++; if (res.timeout || !res.aw_ok || res.data_bad !== 0 || res.wlast_bad !== 0 || res.overrun ||
                         !res.b_ok || !res.idle_ok || (res.gid == exp && res.hs !== int'(r_len[exp[GW-1:0]]) + 1)) begin n_bad++;
                $display("FAIL random_txn[%0d]: got hs=%0d aw=%0b db=%0d wl=%0d ov=%0b b=%0b idle=%0b to=%0b",
                         t, res.hs, res.aw_ok, res.data_bad, res.wlast_bad, res.overrun, res.b_ok, res.idle_ok, res.timeout); end
        end
        s_awvalid = '0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clear_stim();
        test_reset();
        test_single();
        test_contention();
        test_max_burst();
        test_len_mismatch();
        test_reset_mid_data();
        test_isolation();
        test_random();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
